// File: rtl/pitch_detect_if.sv
//==============================================================================
// Module      : pitch_detect_if
// Description : Sample-pop and note-result bundle between the audio controller
//               side (master) and the pitch detector (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pitch_detect_if;
  logic signed [31:0] audio_in;
  logic               read_ready;
  logic               read;
  logic        [6:0]  note_num;
  logic               note_valid;
  logic        [9:0]  period;

  modport master (
    output audio_in, read_ready,
    input  read, note_num, note_valid, period
  );

  modport slave (
    input  audio_in, read_ready,
    output read, note_num, note_valid, period
  );
endinterface

`default_nettype wire

// File: rtl/pitch_detect.sv
//==============================================================================
// Module      : pitch_detect
// Description : Zero-crossing pitch detector with hysteresis, period averaging
//               and note classification. Define PITCH_DETECT_LOCK_EN to only
//               report a note after two consecutive equal classifications.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pitch_detect #(
  parameter int HYST       = 4096,
  parameter int AVG_N_LOG2 = 2,
  parameter int TIMEOUT    = 1023
) (
  input  wire logic     CLOCK_50,
  input  wire logic     reset,
  pitch_detect_if.slave bus
);

  localparam int CNT_W = 10;
  localparam int ACC_W = 12;
  localparam int PC_W  = AVG_N_LOG2 + 1;

  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [PC_W-1:0]   PCNT_FULL = PC_W'(1 << AVG_N_LOG2);
  localparam logic signed [31:0] HYST_POS = 32'(HYST);
  localparam logic signed [31:0] HYST_NEG = -HYST_POS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DETECT   = 2'd2,
    CLASSIFY = 2'd3
  } state_t;

  state_t             state_q;
  logic signed [31:0] sample_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [PC_W-1:0]    pcnt_q;
  logic               have_ref_q;
  logic               armed_q;
  logic               to_done_q;
  logic [6:0]         note_q;
  logic               valid_q;
  logic [9:0]         period_q;
`ifdef PITCH_DETECT_LOCK_EN
  logic [6:0]         cand_q;
  logic               cand_vld_q;
`endif

  logic               arm_d;
  logic               rise_d;
  logic [ACC_W-1:0]   acc_sum_d;
  logic [PC_W-1:0]    pcnt_inc_d;
  logic [6:0]         class_d;

  function automatic logic [6:0] classify(input logic [9:0] p);
    if (p >= 10'd423 && p <= 10'd449) return 7'd22;
    if (p >= 10'd356 && p <= 10'd378) return 7'd25;
    if (p >= 10'd282 && p <= 10'd300) return 7'd29;
    if (p >= 10'd238 && p <= 10'd252) return 7'd32;
    if (p >= 10'd212 && p <= 10'd224) return 7'd34;
    return 7'd0;
  endfunction

  always_comb begin
    arm_d      = (sample_q <= HYST_NEG);
    rise_d     = armed_q && (sample_q >= HYST_POS);
    acc_sum_d  = acc_q + {{(ACC_W-CNT_W){1'b0}}, cnt_q};
    pcnt_inc_d = pcnt_q + PC_W'(1);
    class_d    = classify(period_q);
  end

  // The pop strobe must coincide with the latching edge, so it is decoded
  // straight from the idle state rather than registered.
  assign bus.read       = !reset && (state_q == IDLE) && bus.read_ready;
  assign bus.note_num   = note_q;
  assign bus.note_valid = valid_q;
  assign bus.period     = period_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      pcnt_q     <= '0;
      have_ref_q <= 1'b0;
      armed_q    <= 1'b0;
      to_done_q  <= 1'b0;
      note_q     <= '0;
      valid_q    <= 1'b0;
      period_q   <= '0;
`ifdef PITCH_DETECT_LOCK_EN
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.read_ready) begin
            sample_q <= bus.audio_in;
            state_q  <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (cnt_q != TIMEOUT_C) cnt_q <= cnt_q + 10'd1;
          state_q <= DETECT;
        end

        DETECT: begin
          state_q <= IDLE;
          if (rise_d) begin
            armed_q    <= 1'b0;
            to_done_q  <= 1'b0;
            cnt_q      <= '0;
            have_ref_q <= 1'b1;
            // The first crossing only establishes a phase reference.
            if (have_ref_q) begin
              if (pcnt_inc_d == PCNT_FULL) begin
                period_q <= acc_sum_d[AVG_N_LOG2 +: 10];
                acc_q    <= '0;
                pcnt_q   <= '0;
                state_q  <= CLASSIFY;
              end else begin
                acc_q  <= acc_sum_d;
                pcnt_q <= pcnt_inc_d;
              end
            end
          end else begin
            if (arm_d) armed_q <= 1'b1;
            if (cnt_q == TIMEOUT_C && !to_done_q) begin
              to_done_q  <= 1'b1;
              note_q     <= '0;
              valid_q    <= 1'b1;
              period_q   <= '0;
              acc_q      <= '0;
              pcnt_q     <= '0;
              have_ref_q <= 1'b0;
              armed_q    <= 1'b0;
`ifdef PITCH_DETECT_LOCK_EN
              cand_vld_q <= 1'b0;
`endif
            end
          end
        end

        CLASSIFY: begin
          state_q <= IDLE;
`ifdef PITCH_DETECT_LOCK_EN
          if (cand_vld_q && (class_d == cand_q)) begin
            note_q  <= class_d;
            valid_q <= 1'b1;
          end
          cand_q     <= class_d;
          cand_vld_q <= 1'b1;
`else
          note_q  <= class_d;
          valid_q <= 1'b1;
`endif
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pitch_detect.sv
//==============================================================================
// Module      : tb_pitch_detect
// Description : Self-checking bench for pitch_detect: directed note scenarios
//               plus randomized waves against a sample-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pitch_detect;

  localparam int HYST       = 4096;
  localparam int AVG_N_LOG2 = 2;
  localparam int TIMEOUT    = 1023;
  localparam int AMP        = 32'h0080_0000;
`ifdef PITCH_DETECT_LOCK_EN
  localparam int NCR = 9;
`else
  localparam int NCR = 5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pitch_detect_if bus ();

  pitch_detect #(
    .HYST       (HYST),
    .AVG_N_LOG2 (AVG_N_LOG2),
    .TIMEOUT    (TIMEOUT)
  ) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int g_cyc    = 0;
  bit prev_read = 1'b0;

  // Reference model state: one update per consumed sample
  int m_cnt, m_acc, m_pcnt, m_period, m_cand;
  bit m_ref, m_armed, m_to_done, m_cand_vld;
  int exp_note[$];
  int exp_per[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_note(input int p);
    if (p >= 423 && p <= 449) return 22;
    if (p >= 356 && p <= 378) return 25;
    if (p >= 282 && p <= 300) return 29;
    if (p >= 238 && p <= 252) return 32;
    if (p >= 212 && p <= 224) return 34;
    return 0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_pcnt = 0; m_period = 0; m_cand = 0;
    m_ref = 0; m_armed = 0; m_to_done = 0; m_cand_vld = 0;
    exp_note.delete();
    exp_per.delete();
  endtask

  task automatic emit(input int note);
    exp_note.push_back(note);
    exp_per.push_back(m_period);
  endtask

  task automatic model_sample(input int s);
    bit rise;
    int note;
    rise  = 1'b0;
    m_cnt = (m_cnt < TIMEOUT) ? m_cnt + 1 : TIMEOUT;
    if (s <= -HYST) m_armed = 1'b1;
    else if (m_armed && s >= HYST) begin
      rise    = 1'b1;
      m_armed = 1'b0;
    end
    if (rise) begin
      m_to_done = 1'b0;
      if (m_ref) begin
        m_acc += m_cnt;
        m_pcnt++;
        if (m_pcnt == (1 << AVG_N_LOG2)) begin
          m_period = m_acc / (1 << AVG_N_LOG2);
          m_acc    = 0;
          m_pcnt   = 0;
          note     = ref_note(m_period);
`ifdef PITCH_DETECT_LOCK_EN
          if (m_cand_vld && note == m_cand) emit(note);
          m_cand     = note;
          m_cand_vld = 1'b1;
`else
          emit(note);
`endif
        end
      end
      m_ref = 1'b1;
      m_cnt = 0;
    end else if (m_cnt == TIMEOUT && !m_to_done) begin
      m_to_done  = 1'b1;
      m_period   = 0;
      m_acc      = 0;
      m_pcnt     = 0;
      m_ref      = 1'b0;
      m_armed    = 1'b0;
      m_cand_vld = 1'b0;
      emit(0);
    end
  endtask

  function automatic int wave(input int per, input int k, input int noise);
    int s;
    if (per == 0) s = 0;
    else s = ((k % per) < (per / 2)) ? AMP : -AMP;
    if (noise > 0) s += int'($urandom_range(0, 2 * noise)) - noise;
    return s;
  endfunction

  // One clock: drive inputs, then observe outputs and the pop decision.
  task automatic tick(input bit rdy, input int s, output bit got);
    @(negedge clk);
    g_cyc++;
    bus.read_ready = rdy;
    bus.audio_in   = s;
    #1;
    if (bus.note_valid) begin
      pulses++;
      if (exp_note.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        check("note_num", int'(bus.note_num), exp_note.pop_front());
        check("period", int'(bus.period), exp_per.pop_front());
      end
    end
    got = bus.read;
    if (bus.read) begin
      check("read_gap", int'(prev_read), 0);
      model_sample(s);
    end
    prev_read = bus.read;
  endtask

  // mode 0: ready always, 1: ready one cycle in three, 2: random ready
  task automatic run_wave(input int per, input int k0, input int n,
                          input int noise, input int mode);
    int c, k, cyc;
    bit rdy, got;
    c = 0; k = k0; cyc = 0;
    while (c < n && cyc < n * 8 + 50) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (g_cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tick(rdy, wave(per, k, noise), got);
      cyc++;
      if (got) begin
        c++;
        k++;
      end
    end
    if (c < n) check("sample_budget", c, n);
    repeat (8) tick(1'b0, 0, got);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.read_ready = 1'b1;
    bus.audio_in   = AMP;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read", int'(bus.read), 0);
    check("rst_valid", int'(bus.note_valid), 0);
    check("rst_note", int'(bus.note_num), 0);
    check("rst_period", int'(bus.period), 0);
    rst = 1'b0;
    bus.read_ready = 1'b0;
    prev_read = 1'b0;
    model_reset();
  endtask

  task automatic expect_note(input string tag, input int np, input int note, input int per);
    check({tag, "_pulses"}, pulses, np);
    check({tag, "_note"}, int'(bus.note_num), note);
    check({tag, "_period"}, int'(bus.period), per);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int per, n, noise;
    bus.read_ready = 1'b0;
    bus.audio_in   = 0;
    model_reset();

    do_reset(); pulses = 0;
    run_wave(218, 0, NCR * 218 + 1, 0, 0);
    expect_note("a3", 1, 34, 218);

    do_reset(); pulses = 0;
    run_wave(436, 0, NCR * 436 + 1, 0, 0);
    expect_note("a2", 1, 22, 436);

    do_reset(); pulses = 0;
    run_wave(330, 0, NCR * 330 + 1, 0, 0);
    expect_note("none", 1, 0, 330);

    do_reset(); pulses = 0;
    run_wave(0, 0, 1100, 0, 0);
    expect_note("silence", 1, 0, 0);

    do_reset(); pulses = 0;
    run_wave(218, 0, NCR * 218 + 1, 2000, 0);
    expect_note("noisy", 1, 34, 218);

    do_reset(); pulses = 0;
    run_wave(218, 0, NCR * 218 + 1, 2000, 1);
    expect_note("slow_rdy", 1, 34, 218);

    do_reset();
    run_wave(245, 0, 3 * 245 + 20, 0, 0);
    do_reset(); pulses = 0;
    run_wave(245, 0, NCR * 245, 0, 0);
    check("g3_early_pulses", pulses, 0);
    run_wave(245, NCR * 245, 1, 0, 0);
    expect_note("g3", 1, 32, 245);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      case ($urandom_range(0, 6))
        0:       per = 218;
        1:       per = 245;
        2:       per = 291;
        3:       per = 367;
        4:       per = 436;
        5:       per = 0;
        default: per = int'($urandom_range(150, 1100));
      endcase
      noise = int'($urandom_range(0, HYST - 1));
      n     = (per == 0) ? 1100 : int'($urandom_range(600, 1400));
      run_wave(per, 0, n, noise, 2);
    end
    check("pending_events", exp_note.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
